// File: rtl/wdt_cfg_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// wdt_cfg_pkg
// Shared types and constants for the watchdog configuration arbiter.
//   wdt_reg_sel_e   : register select carried by each requester
//   wdt_cfg_state_e : arbiter FSM states
//   WDT_ADDR_*      : AXI addresses of the WDT registers, plus a helper that
//                     maps an address onto a select for AXI-side requesters
// ---------------------------------------------------------------------------
package wdt_cfg_pkg;

    typedef enum logic [1:0] {
        WDEN_SEL   = 2'd0,
        WDLIVE_SEL = 2'd1,
        WTOCNT_SEL = 2'd2,
        RSVD_SEL   = 2'd3
    } wdt_reg_sel_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        PULSE = 2'd2,
        RESP  = 2'd3
    } wdt_cfg_state_e;

    localparam logic [31:0] WDT_ADDR_WDEN   = 32'h1001_0100;
    localparam logic [31:0] WDT_ADDR_WDLIVE = 32'h1001_0200;
    localparam logic [31:0] WDT_ADDR_WTOCNT = 32'h1001_0300;

    // Unknown addresses map to the reserved select so they come back as errors.
    function automatic wdt_reg_sel_e wdt_addr_to_sel(input logic [31:0] addr);
        wdt_reg_sel_e sel;
        case (addr)
            WDT_ADDR_WDEN:   sel = WDEN_SEL;
            WDT_ADDR_WDLIVE: sel = WDLIVE_SEL;
            WDT_ADDR_WTOCNT: sel = WTOCNT_SEL;
            default:         sel = RSVD_SEL;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/wdt_cfg_arbiter_if.sv
// ---------------------------------------------------------------------------
// wdt_cfg_arbiter_if
// Request/response bundle shared by N_REQ requesters and the arbiter.
//   req_valid/req_sel/req_wdata : per-requester write request (slice i)
//   req_ready                   : one-hot request accept
//   rsp_valid/rsp_err           : one-hot response, error qualified by rsp_valid
//   rsp_ready                   : per-requester response accept
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface wdt_cfg_arbiter_if #(
    parameter int N_REQ  = 2,
    parameter int DATA_W = 32
);
    logic [N_REQ-1:0]        req_valid;
    logic [2*N_REQ-1:0]      req_sel;
    logic [DATA_W*N_REQ-1:0] req_wdata;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0]        rsp_valid;
    logic                    rsp_err;
    logic [N_REQ-1:0]        rsp_ready;

    modport master (
        output req_valid, req_sel, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_err
    );

    modport slave (
        input  req_valid, req_sel, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_err
    );
endinterface

// File: rtl/wdt_cfg_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick: the winner is the first set bit of
// req searching upward from ptr, wrapping modulo N_REQ.
//   req    : request vector
//   ptr    : current round-robin start position
//   grant  : one-hot grant (zero when no request)
//   winner : index of the granted requester
//   any    : at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int PTR_W = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [PTR_W-1:0] winner,
    output logic             any
);

    always_comb begin
        logic [PTR_W-1:0] idx;
        grant  = '0;
        winner = '0;
        any    = 1'b0;
        idx    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = PTR_W'((int'(ptr) + k) % N_REQ);
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                winner     = idx;
            end
        end
    end

endmodule

// File: rtl/wdt_cfg_arbiter.sv
// ---------------------------------------------------------------------------
// wdt_cfg_arbiter
// Shares the single WDT configuration write path between N_REQ requesters,
// served one at a time in round-robin order, one response per request.
// Ports:
//   ACLK, ARESETn : clock, asynchronous active-low reset
//   bus           : wdt_cfg_arbiter_if.slave request/response bundle
//   WDEN          : watchdog enable level
//   WDLIVE        : kick pulse, LIVE_PULSE_CYC cycles wide
//   WTOCNT        : timeout count
//   busy          : FSM not in IDLE
// Build option WDT_CFG_LOCK_EN: while WDEN=1, WTOCNT writes and WDEN=0
// writes are rejected with rsp_err=1, so an enabled watchdog stays enabled
// until reset.
// ---------------------------------------------------------------------------
module wdt_cfg_arbiter
    import wdt_cfg_pkg::*;
#(
    parameter int N_REQ          = 2,
    parameter int DATA_W         = 32,
    parameter int LIVE_PULSE_CYC = 1
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    wdt_cfg_arbiter_if.slave    bus,
    output logic                WDEN,
    output logic                WDLIVE,
    output logic [DATA_W-1:0]   WTOCNT,
    output logic                busy
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(LIVE_PULSE_CYC + 1);

    wdt_cfg_state_e     state, state_nxt;
    logic [PTR_W-1:0]   rr_ptr, win_idx, win_q, ptr_nxt;
    logic [N_REQ-1:0]   grant, win_onehot;
    logic               any_req, grant_fire;
    wdt_reg_sel_e       sel_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [CNT_W-1:0]   pulse_cnt;
    logic               err_q, exec_err;
    logic               wden_q;
    logic [DATA_W-1:0]  wtocnt_q;
    logic [1:0]         sel_arr   [N_REQ];
    logic [DATA_W-1:0]  wdata_arr [N_REQ];

    // Per-requester views of the flattened select/data buses.
    for (genvar g = 0; g < N_REQ; g++) begin : g_slice
        assign sel_arr[g]   = bus.req_sel[2*g +: 2];
        assign wdata_arr[g] = bus.req_wdata[DATA_W*g +: DATA_W];
    end

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .req    (bus.req_valid),
        .ptr    (rr_ptr),
        .grant  (grant),
        .winner (win_idx),
        .any    (any_req)
    );

    assign grant_fire = (state == IDLE) && any_req;
    assign ptr_nxt    = PTR_W'((int'(win_idx) + 1) % N_REQ);
    assign win_onehot = N_REQ'(1) << win_q;

    always_comb begin
        exec_err = 1'b0;
        case (sel_q)
            RSVD_SEL:   exec_err = 1'b1;
`ifdef WDT_CFG_LOCK_EN
            WTOCNT_SEL: exec_err = wden_q;
            WDEN_SEL:   exec_err = wden_q && !(|wdata_q);
`endif
            default:    exec_err = 1'b0;
        endcase
    end

    // FSM state register
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (any_req) state_nxt = EXEC;
            EXEC:  state_nxt = (sel_q == WDLIVE_SEL) ? PULSE : RESP;
            PULSE: if (pulse_cnt <= CNT_W'(1)) state_nxt = RESP;
            RESP:  if (bus.rsp_ready[win_q]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        bus.req_ready = grant_fire ? grant : '0;
        bus.rsp_valid = (state == RESP) ? win_onehot : '0;
        bus.rsp_err   = (state == RESP) && err_q;
        WDLIVE        = (state == PULSE);
        busy          = (state != IDLE);
    end

    // Accept stage: capture the winner's request at the grant edge.
    always_ff @(posedge ACLK) begin
        if (grant_fire) begin
            sel_q   <= wdt_reg_sel_e'(sel_arr[win_idx]);
            wdata_q <= wdata_arr[win_idx];
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rr_ptr <= '0;
            win_q  <= '0;
        end else if (grant_fire) begin
            rr_ptr <= ptr_nxt;
            win_q  <= win_idx;
        end
    end

    // Execute stage: register update, error capture and pulse counter.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wden_q    <= 1'b0;
            wtocnt_q  <= '0;
            err_q     <= 1'b0;
            pulse_cnt <= '0;
        end else if (state == EXEC) begin
            err_q <= exec_err;
            if (!exec_err) begin
                case (sel_q)
                    WDEN_SEL:   wden_q    <= |wdata_q;
                    WTOCNT_SEL: wtocnt_q  <= wdata_q;
                    WDLIVE_SEL: pulse_cnt <= CNT_W'(LIVE_PULSE_CYC);
                    default:    ;
                endcase
            end
        end else if (state == PULSE) begin
            pulse_cnt <= pulse_cnt - CNT_W'(1);
        end
    end

    assign WDEN   = wden_q;
    assign WTOCNT = wtocnt_q;

endmodule

// File: tb/tb_wdt_cfg_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wdt_cfg_arbiter
// Directed bench for wdt_cfg_arbiter (N_REQ=2, DATA_W=32, LIVE_PULSE_CYC=4).
// Inputs change 1 ns after the rising edge; outputs are checked there too.
// Expected values follow WDT_CFG_LOCK_EN when it is defined for the build.
// ---------------------------------------------------------------------------
module tb_wdt_cfg_arbiter;
    import wdt_cfg_pkg::*;

    localparam int LIMIT = 40;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic        WDEN, WDLIVE, busy;
    logic [31:0] WTOCNT;

    logic [1:0]  vld;
    logic [1:0]  rrdy;
    logic [1:0]  sel_v [2];
    logic [31:0] wd_v  [2];

    int n_tests = 0;
    int n_fail  = 0;

    wdt_cfg_arbiter_if #(.N_REQ(2), .DATA_W(32)) bus ();

    assign bus.req_valid = vld;
    assign bus.req_sel   = {sel_v[1], sel_v[0]};
    assign bus.req_wdata = {wd_v[1], wd_v[0]};
    assign bus.rsp_ready = rrdy;

    wdt_cfg_arbiter #(
        .N_REQ          (2),
        .DATA_W         (32),
        .LIVE_PULSE_CYC (4)
    ) dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .bus     (bus),
        .WDEN    (WDEN),
        .WDLIVE  (WDLIVE),
        .WTOCNT  (WTOCNT),
        .busy    (busy)
    );

    always #5 ACLK = ~ACLK;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic wait_ready(input bit idx, input string tag);
        int n = 0;
        while (bus.req_ready[idx] !== 1'b1 && n < LIMIT) begin
            step();
            n++;
        end
        check_eq(tag, (n >= LIMIT), 0);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < LIMIT) begin
            step();
            n++;
        end
        check_eq(tag, (n >= LIMIT), 0);
    endtask

    // Full write transaction from one requester; returns the response error.
    task automatic do_write(input bit idx, input logic [1:0] sel, input logic [31:0] data,
                            output logic err);
        int n = 0;
        vld[idx]   = 1'b1;
        sel_v[idx] = sel;
        wd_v[idx]  = data;
        #1;
        wait_ready(idx, "wr_grant_timeout");
        step();
        vld[idx] = 1'b0;
        while (bus.rsp_valid[idx] !== 1'b1 && n < LIMIT) begin
            step();
            n++;
        end
        check_eq("wr_rsp_timeout", (n >= LIMIT), 0);
        err = bus.rsp_err;
        wait_idle("wr_idle_timeout");
    endtask

    initial begin
        logic       err;
        logic [1:0] exp_g;

        ARESETn  = 1'b0;
        vld      = '0;
        rrdy     = 2'b11;
        sel_v[0] = '0;
        sel_v[1] = '0;
        wd_v[0]  = '0;
        wd_v[1]  = '0;
        repeat (3) @(posedge ACLK);
        #1;

        // Reset state
        check_eq("rst_wden",      WDEN, 0);
        check_eq("rst_wdlive",    WDLIVE, 0);
        check_eq("rst_wtocnt",    WTOCNT, 0);
        check_eq("rst_busy",      busy, 0);
        check_eq("rst_req_ready", bus.req_ready, 0);
        check_eq("rst_rsp_valid", bus.rsp_valid, 0);
        check_eq("rst_rsp_err",   bus.rsp_err, 0);
        ARESETn = 1'b1;
        step();

        // req0 writes WTOCNT=0xFF
        vld[0] = 1'b1; sel_v[0] = 2'd2; wd_v[0] = 32'h0000_00FF;
        #1;
        check_eq("t1_ready_t", bus.req_ready, 2'b01);
        step();
        vld[0] = 1'b0;
        #1;
        check_eq("t1_wtocnt_t1", WTOCNT, 0);
        check_eq("t1_rsp_t1",    bus.rsp_valid, 0);
        check_eq("t1_busy_t1",   busy, 1);
        step();
        check_eq("t1_wtocnt_t2", WTOCNT, 32'hFF);
        check_eq("t1_rsp_t2",    bus.rsp_valid, 2'b01);
        check_eq("t1_err_t2",    bus.rsp_err, 0);
        step();
        check_eq("t1_busy_t3",   busy, 0);

        // req1 kick, pulse 4 cycles
        vld[1] = 1'b1; sel_v[1] = 2'd1; wd_v[1] = 32'h0;
        #1;
        check_eq("t2_ready_t", bus.req_ready, 2'b10);
        step();
        vld[1] = 1'b0;
        #1;
        check_eq("t2_wdlive_t1", WDLIVE, 0);
        for (int c = 0; c < 4; c++) begin
            step();
            check_eq("t2_wdlive_hi", WDLIVE, 1);
            check_eq("t2_rsp_early", bus.rsp_valid, 0);
        end
        step();
        check_eq("t2_wdlive_t6", WDLIVE, 0);
        check_eq("t2_rsp_t6",    bus.rsp_valid, 2'b10);
        check_eq("t2_err_t6",    bus.rsp_err, 0);
        step();
        check_eq("t2_busy_t7",   busy, 0);

        // Both requesters valid: strict alternation, seventh grant shows the wrap
        sel_v[0] = 2'd0; wd_v[0] = 32'h1;
        sel_v[1] = 2'd0; wd_v[1] = 32'h10;
        vld = 2'b11;
        #1;
        exp_g = 2'b01;
        for (int g = 0; g < 7; g++) begin
            int n = 0;
            while (bus.req_ready === 2'b00 && n < LIMIT) begin
                step();
                n++;
            end
            check_eq("t3_grant_timeout", (n >= LIMIT), 0);
            check_eq("t3_grant", bus.req_ready, exp_g);
            exp_g = {exp_g[0], exp_g[1]};
            step();
            if (g == 6) vld = 2'b00;
        end
        wait_idle("t3_idle_timeout");
        check_eq("t3_wden", WDEN, 1);

        // Reserved select with a stalled response
        rrdy = 2'b00;
        vld[0] = 1'b1; sel_v[0] = 2'd3; wd_v[0] = 32'hDEAD;
        #1;
        check_eq("t4_ready", bus.req_ready, 2'b01);
        step();
        vld[0] = 1'b0;
        vld[1] = 1'b1; sel_v[1] = 2'd2; wd_v[1] = 32'h77;
        step();
        check_eq("t4_rsp", bus.rsp_valid, 2'b01);
        check_eq("t4_err", bus.rsp_err, 1);
        for (int c = 0; c < 10; c++) begin
            step();
            check_eq("t4_stall_busy",   busy, 1);
            check_eq("t4_stall_grant",  bus.req_ready, 0);
            check_eq("t4_stall_rsp",    bus.rsp_valid, 2'b01);
            check_eq("t4_stall_err",    bus.rsp_err, 1);
            check_eq("t4_stall_wtocnt", WTOCNT, 32'hFF);
            check_eq("t4_stall_wden",   WDEN, 1);
        end
        vld  = 2'b00;
        rrdy = 2'b11;
        step();
        check_eq("t4_busy_after", busy, 0);
        check_eq("t4_err_after",  bus.rsp_err, 0);

        // Writes while enabled
        do_write(1'b1, 2'd2, 32'd5, err);
`ifdef WDT_CFG_LOCK_EN
        check_eq("t5_wtocnt_err", err, 1);
        check_eq("t5_wtocnt",     WTOCNT, 32'hFF);
`else
        check_eq("t5_wtocnt_err", err, 0);
        check_eq("t5_wtocnt",     WTOCNT, 32'd5);
`endif
        do_write(1'b0, 2'd0, 32'd0, err);
`ifdef WDT_CFG_LOCK_EN
        check_eq("t5_wden0_err", err, 1);
        check_eq("t5_wden0",     WDEN, 1);
`else
        check_eq("t5_wden0_err", err, 0);
        check_eq("t5_wden0",     WDEN, 0);
`endif

        // Reset during PULSE
        do_write(1'b0, 2'd0, 32'd1, err);
        check_eq("t6_wden_err", err, 0);
        check_eq("t6_wden",     WDEN, 1);
        vld[1] = 1'b1; sel_v[1] = 2'd1;
        #1;
        wait_ready(1'b1, "t6_grant_timeout");
        step();
        vld[1] = 1'b0;
        step();
        step();
        check_eq("t6_in_pulse", WDLIVE, 1);
        ARESETn = 1'b0;
        #1;
        check_eq("t6_rst_wdlive", WDLIVE, 0);
        check_eq("t6_rst_wden",   WDEN, 0);
        check_eq("t6_rst_wtocnt", WTOCNT, 0);
        check_eq("t6_rst_busy",   busy, 0);
        step();
        step();
        ARESETn = 1'b1;
        repeat (3) step();
        check_eq("t6_busy_after", busy, 0);
        check_eq("t6_rsp_after",  bus.rsp_valid, 0);

        // Pointer restarts at requester 0 after reset
        sel_v[0] = 2'd2; wd_v[0] = 32'h3;
        sel_v[1] = 2'd2; wd_v[1] = 32'h4;
        vld = 2'b11;
        #1;
        check_eq("t6_ptr_grant", bus.req_ready, 2'b01);
        step();
        vld = 2'b00;
        wait_idle("t6_idle_timeout");
        check_eq("t6_wtocnt_new", WTOCNT, 32'h3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
